// File: rtl/voting_pkg.sv
// voting_pkg: poll session state encodings and the tally saturation limit.
package voting_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_SCAN   = 2'b10,
    ST_RESULT = 2'b11
  } poll_state_e;
  // All-ones value of a w-bit tally, for w up to 32.
  function automatic logic [31:0] tally_max(input int w);
    return (w >= 32) ? 32'hffff_ffff : (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/vote_scan.sv
// vote_scan: sequential arg-max over the tally bank, one candidate per cycle after start.
module vote_scan #(
  parameter int NUM_CAND  = 4,
  parameter int CTR_WIDTH = 16,
  parameter int SEL_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          clr,
  input  logic [NUM_CAND*CTR_WIDTH-1:0] tally_flat,
  output logic [SEL_WIDTH-1:0]          winner,
  output logic                          tie,
  output logic [CTR_WIDTH-1:0]          max_count,
  output logic                          done
);
  logic busy, first, last, gt, tie_n;
  logic [SEL_WIDTH-1:0] idx, win_n;
  logic [CTR_WIDTH-1:0] t, best_n;
  always_comb begin
    t = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (idx == SEL_WIDTH'(i)) t = tally_flat[i*CTR_WIDTH +: CTR_WIDTH];
    first = idx == '0;
    last = idx == SEL_WIDTH'(NUM_CAND - 1);
    gt = first || t > max_count;
    best_n = gt ? t : max_count;
    win_n = gt ? idx : winner;
    tie_n = gt ? 1'b0 : (t == max_count) ? 1'b1 : tie;
    // A shared maximum of zero is not a tie.
    if (last && best_n == '0) tie_n = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      idx <= '0;
      done <= 1'b0;
      winner <= '0;
      tie <= 1'b0;
      max_count <= '0;
    end else begin
      done <= busy & last;
      if (start) begin
        busy <= 1'b1;
        idx <= '0;
      end else if (busy) begin
        busy <= ~last;
        idx <= last ? '0 : idx + SEL_WIDTH'(1);
      end
      if (clr) begin
        winner <= '0;
        tie <= 1'b0;
        max_count <= '0;
      end else if (busy) begin
        winner <= win_n;
        tie <= tie_n;
        max_count <= best_n;
      end
    end
endmodule

// File: rtl/voting_machine_n.sv
// voting_machine_n: N-candidate ballot unit with poll FSM, vote lockout, saturating tallies.
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CTR_WIDTH   = 16,
  parameter int SEL_WIDTH   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
  parameter int LOCKOUT_CYC = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          open_poll,
  input  logic                          close_poll,
  input  logic                          clear,
  input  logic                          enable_btn,
  input  logic [SEL_WIDTH-1:0]          sel,
  output logic                          vote_accepted,
  output logic                          vote_rejected,
  output logic [NUM_CAND*CTR_WIDTH-1:0] tally_flat,
  output logic [1:0]                    state,
  output logic                          result_valid,
  output logic [SEL_WIDTH-1:0]          winner,
  output logic                          tie,
  output logic [CTR_WIDTH-1:0]          max_count
);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CTR_WIDTH-1:0] TALLY_MAX = CTR_WIDTH'(tally_max(CTR_WIDTH));
  poll_state_e st, st_n;
  logic prev_btn, vote_req, accept, clr, scan_start, scan_done;
  logic [LW-1:0] lock;
  logic [CTR_WIDTH-1:0] tally [NUM_CAND];
  logic [NUM_CAND-1:0] hit, room;
  assign vote_req = enable_btn & ~prev_btn;
  assign clr = clear & (st == ST_IDLE || st == ST_RESULT);
  assign scan_start = (st == ST_OPEN) & close_poll;
  // An out-of-range sel matches no candidate, so it can never be accepted.
  assign accept = vote_req & (st == ST_OPEN) & (lock == '0) & |(hit & room);
  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
    assign hit[i] = sel == SEL_WIDTH'(i);
    assign room[i] = tally[i] != TALLY_MAX;
    assign tally_flat[i*CTR_WIDTH +: CTR_WIDTH] = tally[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++)
        tally[i] <= clr ? '0 : (accept & hit[i]) ? tally[i] + CTR_WIDTH'(1) : tally[i];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_btn <= 1'b0;
      lock <= '0;
      vote_accepted <= 1'b0;
      vote_rejected <= 1'b0;
    end else begin
      prev_btn <= enable_btn;
      vote_accepted <= accept;
      vote_rejected <= vote_req & ~accept;
      lock <= accept ? LW'(LOCKOUT_CYC) : (lock != '0) ? lock - LW'(1) : lock;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ST_IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE:   st_n = clear ? ST_IDLE : open_poll ? ST_OPEN : ST_IDLE;
      ST_OPEN:   st_n = close_poll ? ST_SCAN : ST_OPEN;
      ST_SCAN:   st_n = scan_done ? ST_RESULT : ST_SCAN;
      ST_RESULT: st_n = clear ? ST_IDLE : ST_RESULT;
      default:   st_n = ST_IDLE;
    endcase
  end
  always_comb begin
    state = st;
    result_valid = st == ST_RESULT;
  end
  vote_scan #(.NUM_CAND(NUM_CAND), .CTR_WIDTH(CTR_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (scan_start),
    .clr        (clr),
    .tally_flat (tally_flat),
    .winner     (winner),
    .tie        (tie),
    .max_count  (max_count),
    .done       (scan_done)
  );
endmodule

// File: tb/tb_voting_machine_n.sv
// tb_voting_machine_n: two configurations driven in lockstep against a rule-level ballot model.
module tb_voting_machine_n;
  localparam int LOCK = 8;
  logic clk = 1'b0, rst_n = 1'b1, open_poll = 1'b0, close_poll = 1'b0, clear = 1'b0, btn = 1'b0;
  logic [1:0] sel = 2'd0;
  logic d_acc [2], d_rej [2], d_rv [2], d_tie [2];
  logic [1:0] d_st [2], d_win [2];
  logic [63:0] flat_a;
  logic [5:0] flat_b;
  logic [15:0] max_a;
  logic [1:0] max_b;
  int n_vec = 0, n_bad = 0;
  int nc [2] = '{4, 3};
  int tmax [2] = '{65535, 3};
  int m_st [2], m_lock [2], m_cnt [2], m_win [2], m_tie [2], m_max [2];
  int m_tally [2][4];
  bit m_acc [2], m_rej [2], m_prev;

  always #5 clk = ~clk;

  voting_machine_n #(.NUM_CAND(4), .CTR_WIDTH(16), .LOCKOUT_CYC(LOCK)) dut_a (
    .clk(clk), .rst_n(rst_n), .open_poll(open_poll), .close_poll(close_poll), .clear(clear),
    .enable_btn(btn), .sel(sel), .vote_accepted(d_acc[0]), .vote_rejected(d_rej[0]),
    .tally_flat(flat_a), .state(d_st[0]), .result_valid(d_rv[0]), .winner(d_win[0]),
    .tie(d_tie[0]), .max_count(max_a));
  voting_machine_n #(.NUM_CAND(3), .CTR_WIDTH(2), .LOCKOUT_CYC(LOCK)) dut_b (
    .clk(clk), .rst_n(rst_n), .open_poll(open_poll), .close_poll(close_poll), .clear(clear),
    .enable_btn(btn), .sel(sel), .vote_accepted(d_acc[1]), .vote_rejected(d_rej[1]),
    .tally_flat(flat_b), .state(d_st[1]), .result_valid(d_rv[1]), .winner(d_win[1]),
    .tie(d_tie[1]), .max_count(max_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_tally(int k, int i);
    return (k == 0) ? int'(flat_a[i*16 +: 16]) : int'(flat_b[i*2 +: 2]);
  endfunction

  function automatic int dut_max(int k);
    return (k == 0) ? int'(max_a) : int'(max_b);
  endfunction

  task automatic model_clear(int k);
    m_st[k] = 0;
    m_win[k] = 0;
    m_tie[k] = 0;
    m_max[k] = 0;
    for (int i = 0; i < 4; i++) m_tally[k][i] = 0;
  endtask

  task automatic model_reset();
    m_prev = 0;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_lock[k] = 0;
      m_cnt[k] = 0;
      m_acc[k] = 0;
      m_rej[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit req, ok;
    int cnt;
    req = btn && !m_prev;
    for (int k = 0; k < 2; k++) begin
      ok = req && m_st[k] == 1 && int'(sel) < nc[k] && m_lock[k] == 0 && m_tally[k][sel] < tmax[k];
      m_acc[k] = ok;
      m_rej[k] = req && !ok;
      m_lock[k] = ok ? LOCK : (m_lock[k] > 0 ? m_lock[k] - 1 : 0);
      if (ok) m_tally[k][sel]++;
      case (m_st[k])
        0: if (clear) model_clear(k); else if (open_poll) m_st[k] = 1;
        1: if (close_poll) begin m_st[k] = 2; m_cnt[k] = nc[k] + 1; end
        2: begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_st[k] = 3;
            m_max[k] = 0;
            m_win[k] = 0;
            cnt = 0;
            for (int i = 0; i < nc[k]; i++)
              if (m_tally[k][i] > m_max[k]) begin m_max[k] = m_tally[k][i]; m_win[k] = i; end
            for (int i = 0; i < nc[k]; i++) if (m_tally[k][i] == m_max[k]) cnt++;
            m_tie[k] = (cnt > 1 && m_max[k] > 0) ? 1 : 0;
          end
        end
        default: if (clear) model_clear(k);
      endcase
    end
    m_prev = btn;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("state%0d", k), 32'(d_st[k]), m_st[k]);
      check($sformatf("result_valid%0d", k), 32'(d_rv[k]), (m_st[k] == 3) ? 1 : 0);
      check($sformatf("accepted%0d", k), 32'(d_acc[k]), 32'(m_acc[k]));
      check($sformatf("rejected%0d", k), 32'(d_rej[k]), 32'(m_rej[k]));
      for (int i = 0; i < nc[k]; i++)
        check($sformatf("tally%0d_%0d", k, i), dut_tally(k, i), m_tally[k][i]);
      // winner/tie/max_count are undefined while the scan is running
      if (m_st[k] != 2) begin
        check($sformatf("winner%0d", k), 32'(d_win[k]), m_win[k]);
        check($sformatf("tie%0d", k), 32'(d_tie[k]), m_tie[k]);
        check($sformatf("max_count%0d", k), dut_max(k), m_max[k]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic vote(logic [1:0] s);
    sel = s;
    btn = 1'b1;
    step();
    btn = 1'b0;
    idle(10);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    // basic poll: 2,2,1
    open_poll = 1'b1; step(); open_poll = 1'b0;
    vote(2'd2); vote(2'd2); vote(2'd1);
    close_poll = 1'b1; step(); close_poll = 1'b0;
    idle(4);
    check("t1_rv_early", 32'(d_rv[0]), 0);
    step();
    check("t1_rv", 32'(d_rv[0]), 1);
    check("t1_winner", 32'(d_win[0]), 2);
    check("t1_tie", 32'(d_tie[0]), 0);
    check("t1_max", 32'(max_a), 2);
    check("t1_tally2", dut_tally(0, 2), 2);
    // lockout rejection
    clear = 1'b1; step(); clear = 1'b0;
    open_poll = 1'b1; step(); open_poll = 1'b0;
    sel = 2'd0; btn = 1'b1; step();
    check("t2_acc", 32'(d_acc[0]), 1);
    btn = 1'b0; idle(2);
    btn = 1'b1; step();
    check("t2_rej", 32'(d_rej[0]), 1);
    check("t2_tally0", dut_tally(0, 0), 1);
    btn = 1'b0; idle(10);
    // tie between 0 and 3; sel=3 out of range for 3 candidates
    sel = 2'd3; btn = 1'b1; step();
    check("t3_acc_a", 32'(d_acc[0]), 1);
    check("t5_rej_b", 32'(d_rej[1]), 1);
    btn = 1'b0; idle(10);
    close_poll = 1'b1; step(); close_poll = 1'b0;
    idle(5);
    check("t3_winner", 32'(d_win[0]), 0);
    check("t3_tie", 32'(d_tie[0]), 1);
    check("t3_max", 32'(max_a), 1);
    btn = 1'b1; step();
    check("t5_rej_result", 32'(d_rej[0]), 1);
    btn = 1'b0; step();
    clear = 1'b1; step(); clear = 1'b0;
    btn = 1'b1; step();
    check("t5_rej_idle", 32'(d_rej[0]), 1);
    btn = 1'b0; step();
    open_poll = 1'b1; step(); open_poll = 1'b0;
    close_poll = 1'b1; step(); close_poll = 1'b0;
    idle(5);
    check("t3_zero_tie", 32'(d_tie[0]), 0);
    check("t3_zero_max", 32'(max_a), 0);
    // saturation on the 2-bit configuration
    clear = 1'b1; step(); clear = 1'b0;
    open_poll = 1'b1; step(); open_poll = 1'b0;
    vote(2'd1); vote(2'd1); vote(2'd1);
    sel = 2'd1; btn = 1'b1; step();
    check("t4_rej", 32'(d_rej[1]), 1);
    check("t4_tally_b", dut_tally(1, 1), 3);
    check("t4_tally_a", dut_tally(0, 1), 4);
    btn = 1'b0; idle(10);
    // vote together with close
    sel = 2'd2; btn = 1'b1; close_poll = 1'b1; step();
    btn = 1'b0; close_poll = 1'b0;
    check("t6_acc", 32'(d_acc[0]), 1);
    idle(5);
    check("t6_tally2", dut_tally(0, 2), 1);
    check("t6_winner", 32'(d_win[0]), 1);
    clear = 1'b1; step(); clear = 1'b0;
    check("t6_clr_state", 32'(d_st[0]), 0);
    check("t6_clr_tally", dut_tally(0, 1), 0);
    // reset in the middle of a scan
    open_poll = 1'b1; step(); open_poll = 1'b0;
    vote(2'd3);
    close_poll = 1'b1; step(); close_poll = 1'b0;
    idle(2);
    async_reset();
    check("t6_rst_state", 32'(d_st[0]), 0);
    check("t6_rst_tally", dut_tally(0, 3), 0);
    // randomized sessions
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      sel = 2'($urandom_range(0, 3));
      open_poll = $urandom_range(0, 7) == 0;
      close_poll = $urandom_range(0, 49) == 0;
      clear = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 999) == 0) async_reset();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
